// File: rtl/wb_merge.sv
// Writeback merge: in-order pipe results take the register-file port; long-latency results queue in a
// FIFO and retire in idle slots. Optional busy_mask tracking is enabled with WB_BUSY_MASK_EN.
module wb_merge #(
    parameter int unsigned REG_NUMBER     = 32,
    parameter int unsigned REG_WIDTH      = 32,
    parameter int unsigned REG_ADDR_WIDTH = $clog2(REG_NUMBER),
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned STARVE_LIMIT   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipe_wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]     pipe_wb_addr,
    input  logic [REG_WIDTH-1:0]          pipe_wb_data,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [REG_ADDR_WIDTH-1:0]     lu_addr,
    input  logic [REG_WIDTH-1:0]          lu_data,
    output logic                          write_enable,
    output logic [REG_ADDR_WIDTH-1:0]     write_reg_addr,
    output logic [REG_WIDTH-1:0]          write_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
`ifdef WB_BUSY_MASK_EN
    output logic [REG_NUMBER-1:0]         busy_mask,
`endif
    output logic                          stall_req
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT) + 1;

    logic [REG_ADDR_WIDTH-1:0] mem_addr_q [FIFO_DEPTH];
    logic [REG_WIDTH-1:0]      mem_data_q [FIFO_DEPTH];

    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]           count_q, count_d;
    logic [StW-1:0]            starve_q, starve_d;
    logic                      stall_q, stall_d;
    logic                      we_q, we_d;
    logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [REG_WIDTH-1:0]      wdata_q, wdata_d;

    logic pipe_take, fifo_empty, pop, push;

    always_comb begin
        pipe_take  = pipe_wb_valid && (pipe_wb_addr != '0);
        fifo_empty = (count_q == '0);
        pop        = !pipe_take && !fifo_empty;
        lu_ready   = (count_q != CntW'(FIFO_DEPTH));
        // Address-0 results finish the handshake but are never stored.
        push       = lu_valid && lu_ready && (lu_addr != '0);

        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);

        we_d    = pipe_take || pop;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (pipe_take) begin
            waddr_d = pipe_wb_addr;
            wdata_d = pipe_wb_data;
        end else if (pop) begin
            waddr_d = mem_addr_q[rd_ptr_q];
            wdata_d = mem_data_q[rd_ptr_q];
        end

        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != StW'(STARVE_LIMIT - 1)) begin
            starve_d = starve_q + 1'b1;
        end

        stall_d = stall_q;
        if (pop) begin
            stall_d = 1'b0;
        end else if (!fifo_empty && (starve_q == StW'(STARVE_LIMIT - 1))) begin
            stall_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[wr_ptr_q] <= lu_addr;
            mem_data_q[wr_ptr_q] <= lu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
            we_q     <= 1'b0;
            waddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            we_q     <= we_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign write_enable   = we_q;
    assign write_reg_addr = waddr_q;
    assign write_data     = wdata_q;
    assign fifo_count     = count_q;
    assign stall_req      = stall_q;

`ifdef WB_BUSY_MASK_EN
    logic from_lu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            from_lu_q <= 1'b0;
        end else begin
            from_lu_q <= pop;
        end
    end

    always_comb begin
        logic [PtrW-1:0] idx;
        busy_mask = '0;
        idx       = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                busy_mask[mem_addr_q[idx]] = 1'b1;
            end
        end
        if (we_q && from_lu_q) begin
            busy_mask[waddr_q] = 1'b1;
        end
        busy_mask[0] = 1'b0;
    end
`endif

endmodule

// File: tb/tb_wb_merge.sv
// Directed self-checking bench for wb_merge; busy_mask checks compile in with WB_BUSY_MASK_EN.
module tb_wb_merge;

    logic        clk;
    logic        rst_n;
    logic        pipe_wb_valid;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        write_enable;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_data;
    logic [2:0]  fifo_count;
    logic        stall_req;
`ifdef WB_BUSY_MASK_EN
    logic [31:0] busy_mask;
`endif

    int n_cmp;
    int n_bad;

    wb_merge dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_wb_valid  (pipe_wb_valid),
        .pipe_wb_addr   (pipe_wb_addr),
        .pipe_wb_data   (pipe_wb_data),
        .lu_valid       (lu_valid),
        .lu_ready       (lu_ready),
        .lu_addr        (lu_addr),
        .lu_data        (lu_data),
        .write_enable   (write_enable),
        .write_reg_addr (write_reg_addr),
        .write_data     (write_data),
        .fifo_count     (fifo_count),
`ifdef WB_BUSY_MASK_EN
        .busy_mask      (busy_mask),
`endif
        .stall_req      (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic v, input logic [4:0] a, input logic [31:0] d);
        pipe_wb_valid = v;
        pipe_wb_addr  = a;
        pipe_wb_data  = d;
    endtask

    task automatic lu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lu_valid = v;
        lu_addr  = a;
        lu_data  = d;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // Reset with random inputs
        rst_n = 1'b0;
        pipe(1'($urandom), 5'($urandom), $urandom);
        lu(1'($urandom), 5'($urandom), $urandom);
        repeat (3) step();
        check("rst_we", write_enable, 0);
        check("rst_cnt", fifo_count, 0);
        check("rst_ready", lu_ready, 1);
        check("rst_stall", stall_req, 0);
        check("rst_addr", write_reg_addr, 0);
        check("rst_data", write_data, 0);
        pipe(0, 0, 0);
        lu(0, 0, 0);
        rst_n = 1'b1;

        // Pipe-only write, then address 0 discarded with held addr/data
        pipe(1, 5, 32'hDEAD_BEEF);
        step();
        check("pipe_we", write_enable, 1);
        check("pipe_addr", write_reg_addr, 5);
        check("pipe_data", write_data, 32'hDEAD_BEEF);
        pipe(1, 0, 32'h1234_5678);
        step();
        check("pipe0_we", write_enable, 0);
        check("pipe0_hold_addr", write_reg_addr, 5);
        check("pipe0_hold_data", write_data, 32'hDEAD_BEEF);

        // Fill the FIFO while the pipe owns the port
        for (int i = 1; i <= 4; i++) begin
            check("fill_ready", lu_ready, 1);
            pipe(1, 20, i);
            lu(1, 5'(i), 32'h11 * i);
            step();
            check("fill_pipe_addr", write_reg_addr, 20);
        end
        check("full_cnt", fifo_count, 4);
        check("full_ready", lu_ready, 0);
        lu(1, 30, 32'h3030);
        step();
        check("full_nopush_cnt", fifo_count, 4);

        // Drain; an lu_valid during the first pop must not be accepted
        pipe(0, 0, 0);
        lu(1, 25, 32'h99);
        for (int k = 1; k <= 4; k++) begin
            step();
            lu(0, 0, 0);
            check("drain_we", write_enable, 1);
            check("drain_addr", write_reg_addr, 5'(k));
            check("drain_data", write_data, 32'h11 * k);
            check("drain_cnt", fifo_count, 3'(4 - k));
            check("drain_ready", lu_ready, 1);
        end
        step();
        check("drained_we", write_enable, 0);

        // Address-0 long-latency result is not stored
        lu(1, 0, 32'h5555);
        step();
        check("lu0_cnt", fifo_count, 0);
        check("lu0_we", write_enable, 0);

        // Shared slot with simultaneous push and pop
        pipe(1, 3, 32'h33);
        lu(1, 7, 32'h77);
        step();
        check("share_pipe_addr", write_reg_addr, 3);
        check("share_cnt1", fifo_count, 1);
        pipe(1, 0, 32'hBAD);
        lu(1, 8, 32'h88);
        step();
        check("share_we", write_enable, 1);
        check("share_addr7", write_reg_addr, 7);
        check("share_data7", write_data, 32'h77);
        check("pushpop_cnt", fifo_count, 1);
        pipe(0, 0, 0);
        lu(0, 0, 0);
        step();
        check("pushpop_addr8", write_reg_addr, 8);
        check("pushpop_data8", write_data, 32'h88);
        check("pushpop_cnt0", fifo_count, 0);

        // Starvation
        pipe(1, 2, 32'h2);
        lu(1, 10, 32'hAA);
        step();
        lu(0, 0, 0);
        repeat (7) step();
        check("starve_7", stall_req, 0);
        step();
        check("starve_8", stall_req, 1);
        step();
        check("starve_hold", stall_req, 1);
        check("starve_pipe_wins", write_reg_addr, 2);
        pipe(0, 0, 0);
        step();
        check("starve_pop_addr", write_reg_addr, 10);
        check("starve_pop_data", write_data, 32'hAA);
        check("starve_clear", stall_req, 0);
        step();

        // Asynchronous reset mid-operation
        pipe(1, 4, 32'h4);
        lu(1, 11, 32'hB1);
        step();
        lu(1, 12, 32'hB2);
        step();
        check("mid_cnt", fifo_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_cnt", fifo_count, 0);
        check("mid_rst_we", write_enable, 0);
        pipe(0, 0, 0);
        lu(0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        check("mid_after_we", write_enable, 0);
        check("mid_after_cnt", fifo_count, 0);

`ifdef WB_BUSY_MASK_EN
        pipe(1, 20, 32'h20);
        lu(1, 9, 32'h99);
        step();
        lu(1, 12, 32'hCC);
        step();
        lu(0, 0, 0);
        check("mask_both", busy_mask, 32'h0000_1200);
        pipe(0, 0, 0);
        step();
        check("mask_pop9", busy_mask, 32'h0000_1200);
        step();
        check("mask_pop12", busy_mask, 32'h0000_1000);
        step();
        check("mask_clear", busy_mask, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_merge.md
Name: wb_merge

Overview:
- Writeback merge stage directly upstream of the register file write port.
- Combines two result sources onto the single write port:
  - the in-order pipeline result, which cannot stall;
  - a long-latency unit (mul/div/load-miss) result, delivered over a valid/ready handshake.
- Long-latency results are buffered in a small FIFO and retired in idle writeback slots.
- Output is registered and drives write_enable/write_reg_addr/write_data of the register file.

Parameters:
REG_NUMBER, 32, number of architectural registers
REG_WIDTH, 32, data width
REG_ADDR_WIDTH, $clog2(REG_NUMBER), register address width
FIFO_DEPTH, 4, long-latency buffer entries; power of two, >= 2
STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO head may wait before stall_req asserts

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pipe_wb_valid  in  1  pipeline result valid this cycle
pipe_wb_addr  in  REG_ADDR_WIDTH  pipeline destination register
pipe_wb_data  in  REG_WIDTH  pipeline result
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept; equals (count != FIFO_DEPTH)
lu_addr  in  REG_ADDR_WIDTH  long-latency destination register
lu_data  in  REG_WIDTH  long-latency result
write_enable  out  1  register-file write strobe (registered)
write_reg_addr  out  REG_ADDR_WIDTH  register-file write address (registered)
write_data  out  REG_WIDTH  register-file write data (registered)
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
stall_req  out  1  request that upstream hold off pipeline writebacks (registered)

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - write_enable=0, write_reg_addr=0, write_data=0.
  - FIFO empty, fifo_count=0, stall_req=0, starve counter=0.
  - lu_ready=1 once count is 0, including while in reset.
- Latency: a pipeline result valid in cycle N appears on the write port in cycle N+1.
- Slot selection at each rising edge, in priority order:
  1. pipe_wb_valid && pipe_wb_addr!=0: load pipe result, write_enable=1.
  2. Else FIFO non-empty: pop head into output register, write_enable=1.
  3. Else write_enable=0; addr/data hold their previous values.
- Pipe writes with addr 0 are discarded and free the slot for a FIFO pop in the same cycle.
- Push: occurs when lu_valid && lu_ready.
  - Entries with lu_addr==0 complete the handshake but are not stored.
  - lu_ready depends only on the registered count. A pop in the same cycle does not make a full FIFO ready.
- Simultaneous push and pop: count unchanged; the head advances and the new entry is appended at the tail.
- Ordering: FIFO entries retire strictly in arrival order. Pipe-vs-FIFO WAW ordering on the same rd is guaranteed by issue logic, not by this block.
- Pointers: $clog2(FIFO_DEPTH) bits each, natural wrap. count is saturating-free. Pushing when full or popping when empty is impossible by construction.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs.
  - Clears on any pop or when the FIFO is empty.
  - stall_req is set when the counter reaches STARVE_LIMIT-1 and a pop does not occur that cycle.
  - stall_req clears on the cycle after the next pop.
  - If pipe_wb_valid arrives while stall_req=1, the pipe still wins. This is a protocol violation; no data is lost.
- Reset mid-operation: all buffered entries are dropped immediately and no write is issued.

Optional Feature:
- Macro: WB_BUSY_MASK_EN.
- Defined:
  - Adds output busy_mask[REG_NUMBER-1:0].
  - Bit r is 1 while any FIFO entry targets register r, or while the long-latency result for r is in the output register with write_enable=1.
  - Computed from registered state only.
  - Bit 0 is always 0.
  - Issue logic uses busy_mask to stall RAW/WAW hazards.
- Not defined: port absent and no tracking logic; issue logic relies on external scoreboarding.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> write_enable=0, fifo_count=0, lu_ready=1, stall_req=0.
- Pipe only: pipe_wb_valid=1, addr=5, data=0xDEADBEEF at cycle N -> cycle N+1 shows write_enable=1, write_reg_addr=5, write_data=0xDEADBEEF. The same input with addr=0 gives write_enable=0.
- FIFO fill/drain: push 4 lu results (addr 1..4, data 0x11..0x44) while pipe is busy -> lu_ready=0 after the 4th. Drop pipe_wb_valid -> writes of 1,2,3,4 on 4 consecutive cycles, lu_ready=1 after the first pop.
- Shared slot: pipe_wb_valid=1 with addr 0 and FIFO holding addr 7 -> addr 7 is written the next cycle.
- Starvation: one FIFO entry with pipe valid every cycle (addr!=0) -> stall_req rises after 8 waiting cycles. Drop pipe_wb_valid for one cycle -> pop, and stall_req falls on the following cycle.
- WB_BUSY_MASK_EN: push addr 9 then addr 12 -> busy_mask has bits 9 and 12 set. Each bit clears on the cycle after its write.
